// File: rtl/spi_slave.sv
// SPI mode-0 byte slave running entirely in the clk domain, with oversampled pins and a one-deep TX buffer.
// Optional SPI_SLAVE_OVERRUN_EN: rd_valid becomes a level acknowledged by rd_ack, with rx_overrun flagging lost bytes.
module spi_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] data_wr,
    input  logic       wr_en,
    output logic       tx_ready,
    output logic [7:0] data_rd,
    output logic       rd_valid,
    output logic [1:0] state,
    output logic [2:0] count
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic       rd_ack,
    output logic       rx_overrun
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RELOAD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   sclk_sync;
    logic                   cs_sync;
    logic                   mosi_sync;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       load_tx;
    logic       shift_tx;
    logic       rx_en;
    logic       byte_done;

    logic [7:0] tx_shift;
    logic [6:0] rx_shift;
    logic [7:0] tx_buf;
    logic       buf_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q    <= '0;
            cs_q      <= '1;
            mosi_q    <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
            cs_q      <= {cs_q[SYNC_STAGES-2:0], cs};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_q[SYNC_STAGES-1];
            cs_prev   <= cs_q[SYNC_STAGES-1];
        end
    end

    assign sclk_sync = sclk_q[SYNC_STAGES-1];
    assign cs_sync   = cs_q[SYNC_STAGES-1];
    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    // SPI clock edges are qualified with the delayed cs so a byte finishing on the cs-rise clk still lands.
    assign sclk_rise = sclk_sync & ~sclk_prev & ~cs_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev & ~cs_prev;
    assign cs_fall   = ~cs_sync & cs_prev;
    assign cs_rise   = cs_sync & ~cs_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        load_tx   = 1'b0;
        shift_tx  = 1'b0;
        rx_en     = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    load_tx = 1'b1;
                    count_d = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_en   = 1'b1;
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        byte_done = 1'b1;
                        state_d   = RELOAD;
                    end
                end else if (sclk_fall && count_q != 3'd0) begin
                    shift_tx = 1'b1;
                end
            end
            RELOAD: begin
                // The fall that ends bit 7 reloads instead of shifting.
                if (sclk_fall) begin
                    load_tx = 1'b1;
                    count_d = 3'd0;
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
        endcase
        if (cs_rise) begin
            state_d  = IDLE;
            count_d  = 3'd0;
            load_tx  = 1'b0;
            shift_tx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            tx_buf     <= '0;
            buf_full   <= 1'b0;
            data_rd    <= '0;
            rd_valid   <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            rx_overrun <= 1'b0;
`endif
        end else begin
            if (load_tx) begin
                tx_shift <= buf_full ? tx_buf : IDLE_BYTE;
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            // A load and a write in the same clk: the load wins and the host must retry.
            if (load_tx && buf_full) begin
                buf_full <= 1'b0;
            end else if (wr_en && !buf_full) begin
                tx_buf   <= data_wr;
                buf_full <= 1'b1;
            end

            if (rx_en) begin
                rx_shift <= {rx_shift[5:0], mosi_sync};
            end
            if (byte_done) begin
                data_rd <= {rx_shift, mosi_sync};
            end

`ifdef SPI_SLAVE_OVERRUN_EN
            if (rd_ack) begin
                rd_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (byte_done) begin
                rd_valid <= 1'b1;
                if (rd_valid && !rd_ack) begin
                    rx_overrun <= 1'b1;
                end
            end
`else
            rd_valid <= byte_done;
`endif
        end
    end

    assign miso     = (state_q == IDLE) ? 1'b0 : tx_shift[7];
    assign tx_ready = ~buf_full;
    assign state    = state_q;
    assign count    = count_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bus-functional SPI master with RX/MISO scoreboards checked by immediate assertions.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] data_wr;
    logic       wr_en;
    logic       tx_ready;
    logic [7:0] data_rd;
    logic       rd_valid;
    logic [1:0] state;
    logic [2:0] count;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rd_ack;
    logic       rx_overrun;
`endif

    int         checks = 0;
    int         errors = 0;
    int         rd_count = 0;
    int         rd_base;
    int         k;
    bit         mon_en = 1'b0;
    logic       rd_prev = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    spi_slave dut (
        .clk      (clk),
        .reset    (reset),
        .spi_clk  (spi_clk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .data_wr  (data_wr),
        .wr_en    (wr_en),
        .tx_ready (tx_ready),
        .data_rd  (data_rd),
        .rd_valid (rd_valid),
        .state    (state),
        .count    (count)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .rd_ack     (rd_ack),
        .rx_overrun (rx_overrun)
`endif
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each received-byte strobe pops the oldest expected byte.
    always @(negedge clk) begin
        if (mon_en && rd_valid === 1'b1) begin
            rd_count <= rd_count + 1;
            check("rd_valid_width", {31'd0, rd_prev}, 32'd0);
            checks++;
            assert (rx_q.size() > 0) else begin
                errors++;
                $error("FAIL rd_valid_unexpected: observed data_rd=%0h expected=no strobe", data_rd);
            end
            if (rx_q.size() > 0) check("data_rd", {24'd0, data_rd}, {24'd0, rx_q.pop_front()});
        end
        rd_prev <= rd_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_buf(input logic [7:0] d);
        @(negedge clk);
        data_wr = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(2);
        cs   = 1'b1;
        mosi = 1'b0;
        tick(6);
    endtask

    // The master samples miso at the end of the high phase, which covers the slave's synchronizer latency.
    task automatic xfer(input logic [7:0] mo, input int nbits, input logic [7:0] exp_miso, input bit full);
        logic [7:0] got;
        got = 8'h00;
        if (full) begin
            rx_q.push_back(mo);
            miso_q.push_back(exp_miso);
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            tick(2);
            spi_clk = 1'b1;
            tick(2);
            got[7-i] = miso;
            spi_clk = 1'b0;
        end
        if (full) check("miso_byte", {24'd0, got}, {24'd0, miso_q.pop_front()});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_miso"},     {31'd0, miso},     32'd0);
        check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        check({tag, "_data_rd"},  {24'd0, data_rd},  32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_state"},    {30'd0, state},    32'd0);
        check({tag, "_count"},    {29'd0, count},    32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, {30'd0, state}, 32'd0);
        check({tag, "_count"}, {29'd0, count}, 32'd0);
        check({tag, "_miso"},  {31'd0, miso},  32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        cs      = 1'b1;
        spi_clk = 1'b0;
        mosi    = 1'b0;
        wr_en   = 1'b0;
        data_wr = 8'h00;
`ifdef SPI_SLAVE_OVERRUN_EN
        rd_ack  = 1'b1;
`endif
        tick(3);
        check_reset_vals("por");
        reset = 1'b0;
        tick(3);
        mon_en = 1'b1;

        // Reset in the middle of a frame, then a clean frame.
        write_buf(8'h99);
        cs_low();
        xfer(8'hC3, 3, 8'h00, 1'b0);
        tick(2);
        check("midframe_count", {29'd0, count}, 32'd3);
        check("midframe_state", {30'd0, state}, 32'd1);
        #10 reset = 1'b1;
        #1 check_reset_vals("midrst");
        cs      = 1'b1;
        spi_clk = 1'b0;
        mosi    = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(4);
        cs_low();
        xfer(8'h5A, 8, 8'h00, 1'b1);
        cs_high();

        // Single frame with a buffered byte.
        write_buf(8'h3C);
        check("tx_ready_after_wr", {31'd0, tx_ready}, 32'd0);
        cs_low();
        check("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
        xfer(8'hAB, 8, 8'h3C, 1'b1);
        cs_high();
        check_idle("single_end");

        // Empty buffer shifts IDLE_BYTE.
        cs_low();
        xfer(8'h55, 8, 8'h00, 1'b1);
        cs_high();

        // Back-to-back bytes in one cs-low period.
        rd_base = rd_count;
        write_buf(8'hA1);
        cs_low();
        k = 0;
        while (tx_ready !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("b2b_tx_ready_rise", {31'd0, tx_ready}, 32'd1);
        write_buf(8'hB2);
        check("b2b_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        xfer(8'h01, 8, 8'hA1, 1'b1);
        xfer(8'h02, 8, 8'hB2, 1'b1);
        cs_high();
        check("b2b_rd_pulses", rd_count - rd_base, 32'd2);
        check("b2b_tx_ready_end", {31'd0, tx_ready}, 32'd1);

        // Aborted frame after 5 bits, then a full frame.
        rd_base = rd_count;
        cs_low();
        xfer(8'hF0, 5, 8'h00, 1'b0);
        cs_high();
        check("abort_no_rd", rd_count - rd_base, 32'd0);
        check_idle("abort");
        cs_low();
        xfer(8'h0F, 8, 8'h00, 1'b1);
        cs_high();
        check("abort_next_data", {24'd0, data_rd}, 32'h0F);

        // Write while the buffer is full is dropped.
        write_buf(8'h77);
        write_buf(8'h88);
        check("ignored_wr_tx_ready", {31'd0, tx_ready}, 32'd0);
        cs_low();
        xfer(8'h66, 8, 8'h77, 1'b1);
        cs_high();
        cs_low();
        xfer(8'hE7, 8, 8'h00, 1'b1);
        cs_high();

`ifdef SPI_SLAVE_OVERRUN_EN
        mon_en = 1'b0;
        rd_ack = 1'b0;
        cs_low();
        xfer(8'h11, 8, 8'h00, 1'b0);
        cs_high();
        cs_low();
        xfer(8'h22, 8, 8'h00, 1'b0);
        cs_high();
        check("ovr_data_rd",    {24'd0, data_rd},    32'h22);
        check("ovr_rd_valid",   {31'd0, rd_valid},   32'd1);
        check("ovr_rx_overrun", {31'd0, rx_overrun}, 32'd1);
        rd_ack = 1'b1;
        tick(1);
        check("ack_rd_valid",   {31'd0, rd_valid},   32'd0);
        check("ack_rx_overrun", {31'd0, rx_overrun}, 32'd0);
        mon_en = 1'b1;
`endif

        tick(4);
        check("rx_scoreboard_empty", rx_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
